sipo_deser: RTL

//  Receive-side serial-in/parallel-out deserializer for the 10-bit SerDes link.
//  - Takes one LSB-first bit per qualified clk and rebuilds 10-bit symbols.
//  - Optionally aligns symbol boundaries on the K28.5 comma.
//  - Delivers words to the downstream 8b/10b decoder.

---
 rtl/serdes_pkg.sv | 19 +
 rtl/serdes_comma_det.sv | 20 ++
 rtl/sipo_deser.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: shared constants and types for the 10-bit SerDes receive path.
//   DATA_W     symbol width in bits
//   K28_5_RDN  K28.5 comma, RD- polarity, as received (bit0 = first bit on the wire)
//   K28_5_RDP  K28.5 comma, RD+ polarity, as received
//   MIS_MAX    consecutive off-boundary commas before alignment is dropped
//   align_state_t  comma-alignment FSM states (used when SIPO_ALIGN_EN is defined)
package serdes_pkg;

  localparam int DATA_W = 10;
  localparam logic [DATA_W-1:0] K28_5_RDN = 10'h17C;
  localparam logic [DATA_W-1:0] K28_5_RDP = 10'h283;
  localparam int MIS_MAX = 3;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } align_state_t;

endpackage

// File: rtl/serdes_comma_det.sv
// serdes_comma_det: combinational compare of a DATA_W window against both
// K28.5 comma polarities.
// Ports:
//   window   in   DATA_W  candidate symbol, bit0 = oldest bit
//   match    out  1       window equals COMMA_P or COMMA_N
//   match_p  out  1       window equals COMMA_P (RD- polarity)
module serdes_comma_det #(
  parameter int DATA_W = serdes_pkg::DATA_W,
  parameter logic [DATA_W-1:0] COMMA_P = serdes_pkg::K28_5_RDN,
  parameter logic [DATA_W-1:0] COMMA_N = serdes_pkg::K28_5_RDP
) (
  input  logic [DATA_W-1:0] window,
  output logic              match,
  output logic              match_p
);

  assign match_p = (window == COMMA_P);
  assign match   = match_p | (window == COMMA_N);

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: receive-side serial-in/parallel-out deserializer for the 10-bit
// SerDes link. Rebuilds LSB-first symbols and hands them to the 8b/10b decoder.
//
// Optional feature macro: SIPO_ALIGN_EN
//   defined   -> HUNT/SYNC comma alignment on K28.5, framing loss after
//                MIS_MAX consecutive off-boundary commas.
//   undefined -> free-running framing from the first valid bit after reset,
//                aligned=1 from the first clk after reset release.
//
// Ports:
//   clk           in   1       receive bit clock
//   rst_n         in   1       asynchronous active-low reset
//   serial_in     in   1       serial data, LSB of each symbol first
//   bit_valid     in   1       serial_in is sampled only when high
//   parallel_out  out  DATA_W  deserialized symbol, bit0 = first bit received
//   data_valid    out  1       one-cycle pulse: parallel_out holds a new word
//   comma_det     out  1       qualifies data_valid: word is a K28.5 comma
//   aligned       out  1       symbol framing is locked
//
// Handshake: there is no backpressure. A word is offered for exactly one clk
// with data_valid=1; comma_det is only ever high in that same cycle.
// parallel_out holds the last emitted word until the next one.
module sipo_deser #(
  parameter int DATA_W = serdes_pkg::DATA_W,
  parameter logic [DATA_W-1:0] COMMA_P = serdes_pkg::K28_5_RDN,
  parameter logic [DATA_W-1:0] COMMA_N = serdes_pkg::K28_5_RDP
`ifdef SIPO_ALIGN_EN
  ,
  parameter int MIS_MAX = serdes_pkg::MIS_MAX
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] parallel_out,
  output logic              data_valid,
  output logic              comma_det,
  output logic              aligned
);

  import serdes_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] nxt;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] parallel_out_q, parallel_out_d;
  logic              data_valid_q, data_valid_d;
  logic              comma_det_q, comma_det_d;
  logic              aligned_q, aligned_d;
  logic              win_match, win_match_p;
  logic              is_comma;
  logic              boundary;

  // Window as it will look once the current bit is shifted in; all decisions
  // for this bit are made on it so a word is emitted the cycle after its last bit.
  assign nxt      = {serial_in, sr_q[DATA_W-1:1]};
  assign boundary = (bit_cnt_q == LAST_BIT);

  serdes_comma_det #(
    .DATA_W  (DATA_W),
    .COMMA_P (COMMA_P),
    .COMMA_N (COMMA_N)
  ) u_comma_det (
    .window  (nxt),
    .match   (win_match),
    .match_p (win_match_p)
  );

  // Either polarity counts as a comma.
  assign is_comma = win_match | win_match_p;

`ifdef SIPO_ALIGN_EN
  localparam int MIS_W = $clog2(MIS_MAX + 1);
  localparam logic [MIS_W-1:0] MIS_LAST = MIS_W'(MIS_MAX - 1);

  align_state_t     state_q, state_d;
  logic [MIS_W-1:0] mis_cnt_q, mis_cnt_d;
`endif

  always_comb begin
    sr_d           = sr_q;
    bit_cnt_d      = bit_cnt_q;
    parallel_out_d = parallel_out_q;
    data_valid_d   = 1'b0;
    comma_det_d    = 1'b0;
    aligned_d      = aligned_q;

    if (bit_valid) begin
      sr_d = nxt;
    end

`ifdef SIPO_ALIGN_EN
    state_d   = state_q;
    mis_cnt_d = mis_cnt_q;

    case (state_q)
      HUNT: begin
        aligned_d = 1'b0;
        bit_cnt_d = '0;
        if (bit_valid && is_comma) begin
          parallel_out_d = nxt;
          data_valid_d   = 1'b1;
          comma_det_d    = 1'b1;
          mis_cnt_d      = '0;
          state_d        = SYNC;
          aligned_d      = 1'b1;
        end
      end

      SYNC: begin
        aligned_d = 1'b1;
        if (bit_valid) begin
          if (boundary) begin
            parallel_out_d = nxt;
            data_valid_d   = 1'b1;
            comma_det_d    = is_comma;
            bit_cnt_d      = '0;
            if (is_comma) begin
              mis_cnt_d = '0;
            end
          end else if (is_comma && (mis_cnt_q == MIS_LAST)) begin
            // Framing lost: the word in progress is dropped, and this comma is
            // not reused; HUNT starts on the next valid bit.
            state_d   = HUNT;
            aligned_d = 1'b0;
            bit_cnt_d = '0;
            mis_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (is_comma) begin
              mis_cnt_d = mis_cnt_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d   = HUNT;
        aligned_d = 1'b0;
        bit_cnt_d = '0;
        mis_cnt_d = '0;
      end
    endcase
`else
    aligned_d = 1'b1;
    if (bit_valid) begin
      if (boundary) begin
        parallel_out_d = nxt;
        data_valid_d   = 1'b1;
        comma_det_d    = is_comma;
        bit_cnt_d      = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q           <= '0;
      bit_cnt_q      <= '0;
      parallel_out_q <= '0;
      data_valid_q   <= 1'b0;
      comma_det_q    <= 1'b0;
      aligned_q      <= 1'b0;
    end else begin
      sr_q           <= sr_d;
      bit_cnt_q      <= bit_cnt_d;
      parallel_out_q <= parallel_out_d;
      data_valid_q   <= data_valid_d;
      comma_det_q    <= comma_det_d;
      aligned_q      <= aligned_d;
    end
  end

`ifdef SIPO_ALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      mis_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
`endif

  assign parallel_out = parallel_out_q;
  assign data_valid   = data_valid_q;
  assign comma_det    = comma_det_q;
  assign aligned      = aligned_q;

endmodule
